// File: rtl/in_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module   : in_packetizer_if
// Purpose  : FIFO-side and encoder-side handshake bundle for in_packetizer.
// Revision : 1.0
// ============================================================================
interface in_packetizer_if;
  logic       in_req_o;
  logic       in_ready_o;
  logic       in_data_ack_o;
  logic [7:0] in_data_i;
  logic       in_valid_i;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;

  modport master (
    output in_req_o, in_ready_o, in_data_ack_o, tx_data_o, tx_valid_o,
    input  in_data_i, in_valid_i, tx_ready_i
  );

  modport slave (
    input  in_req_o, in_ready_o, in_data_ack_o, tx_data_o, tx_valid_o,
    output in_data_i, in_valid_i, tx_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/in_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : in_packetizer
// Purpose  : USB IN data-packet transmitter between the IN FIFO and TX encoder.
//            Macro IN_NAK_EMPTY_EN: answer an empty FIFO with NAK, not a ZLP.
// Revision : 1.0
// ============================================================================
module in_packetizer #(
  parameter int IN_MAXPACKETSIZE = 8
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clk_gate_i,
  input  logic token_in_i,
  input  logic hs_ack_i,
  input  logic hs_timeout_i,
  input  logic toggle_clr_i,
  output logic busy_o,
  in_packetizer_if.master bus
);

  localparam int              CNT_W     = $clog2(IN_MAXPACKETSIZE + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(IN_MAXPACKETSIZE);
  localparam logic [7:0]      PID_DATA0 = 8'hC3;
  localparam logic [7:0]      PID_DATA1 = 8'h4B;
`ifdef IN_NAK_EMPTY_EN
  localparam logic [7:0]      PID_NAK   = 8'h5A;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PID     = 3'd1,
    DATA    = 3'd2,
    CRC_LO  = 3'd3,
    CRC_HI  = 3'd4,
    WAIT_HS = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic             toggle, toggle_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [15:0]      crc, crc_nxt;
  logic             req, req_nxt;
  logic             rdy, rdy_nxt;
  logic             ack, ack_nxt;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             data_valid;

  // Reflected USB CRC16 fold of one byte, LSB first.
  function automatic logic [15:0] crc16_fold(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      toggle <= 1'b0;
      count  <= '0;
      crc    <= 16'hFFFF;
      req    <= 1'b0;
      rdy    <= 1'b0;
      ack    <= 1'b0;
    end else if (clk_gate_i) begin
      state  <= state_nxt;
      toggle <= toggle_nxt;
      count  <= count_nxt;
      crc    <= crc_nxt;
      req    <= req_nxt;
      rdy    <= rdy_nxt;
      ack    <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    toggle_nxt = toggle;
    count_nxt  = count;
    crc_nxt    = crc;
    req_nxt    = 1'b0;
    rdy_nxt    = 1'b0;
    ack_nxt    = 1'b0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    data_valid = bus.in_valid_i && (count < MAX_CNT);

    case (state)
      IDLE: begin
        if (token_in_i) begin
          req_nxt   = 1'b1;
          rdy_nxt   = 1'b1;
          count_nxt = '0;
          crc_nxt   = 16'hFFFF;
          state_nxt = PID;
        end
      end
      PID: begin
`ifdef IN_NAK_EMPTY_EN
        // Hold off until the rewind has landed so in_valid_i reflects the retry data.
        tx_valid = !req;
        tx_data  = bus.in_valid_i ? (toggle ? PID_DATA1 : PID_DATA0) : PID_NAK;
        if (tx_valid && bus.tx_ready_i)
          state_nxt = bus.in_valid_i ? DATA : IDLE;
`else
        tx_valid = 1'b1;
        tx_data  = toggle ? PID_DATA1 : PID_DATA0;
        if (bus.tx_ready_i)
          state_nxt = DATA;
`endif
      end
      DATA: begin
        tx_valid = data_valid;
        tx_data  = bus.in_data_i;
        if (!data_valid) begin
          state_nxt = CRC_LO;
        end else if (bus.tx_ready_i) begin
          rdy_nxt   = 1'b1;
          crc_nxt   = crc16_fold(crc, bus.in_data_i);
          count_nxt = count + CNT_W'(1);
        end
      end
      CRC_LO: begin
        tx_valid = 1'b1;
        tx_data  = ~crc[7:0];
        if (bus.tx_ready_i) state_nxt = CRC_HI;
      end
      CRC_HI: begin
        tx_valid = 1'b1;
        tx_data  = ~crc[15:8];
        if (bus.tx_ready_i) state_nxt = WAIT_HS;
      end
      WAIT_HS: begin
        if (hs_ack_i) begin
          rdy_nxt    = 1'b1;
          ack_nxt    = 1'b1;
          toggle_nxt = ~toggle;
          state_nxt  = IDLE;
        end else if (hs_timeout_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (toggle_clr_i) toggle_nxt = 1'b0;
  end

  assign bus.in_req_o      = req;
  assign bus.in_ready_o    = rdy;
  assign bus.in_data_ack_o = ack;
  assign bus.tx_data_o     = tx_data;
  assign bus.tx_valid_o    = tx_valid;
  assign busy_o            = (state != IDLE);

endmodule
`default_nettype wire

// File: doc/in_packetizer.md
Name: in_packetizer

Overview:
- SIE-side IN data packet transmitter. Sits directly downstream of the IN FIFO and drives its in_req/in_ready/in_data_ack handshake.
- On an IN token for the endpoint it sends the data packet to the byte-level TX encoder: DATAx PID, up to IN_MAXPACKETSIZE payload bytes pulled from the FIFO, then the CRC16.
- It then waits for the host handshake. An ACK commits the data in the FIFO. A timeout leaves the data in place for retry.

Parameters:
- IN_MAXPACKETSIZE, 8, maximum payload bytes per packet (1..64).

Ports:
- clk_i  input  1  clock, 12MHz*BIT_SAMPLES.
- rstn_i  input  1  asynchronous active-low reset.
- clk_gate_i  input  1  one-clk_i enable per bit time; all state updates qualified by it.
- token_in_i  input  1  IN token addressed to this endpoint received; one gate period.
- hs_ack_i  input  1  host ACK handshake received; one gate period.
- hs_timeout_i  input  1  handshake timeout or corrupt handshake; one gate period.
- toggle_clr_i  input  1  clear data toggle to DATA0 (SETUP/SET_CONFIG/bus reset); gate-qualified.
- in_data_i  input  8  FIFO head byte.
- in_valid_i  input  1  FIFO has unsent byte.
- in_req_o  output  1  to FIFO: new packet request (rewind).
- in_ready_o  output  1  to FIFO: handshake strobe, one gate period.
- in_data_ack_o  output  1  to FIFO: commit sent bytes.
- tx_data_o  output  8  byte to encoder.
- tx_valid_o  output  1  tx_data_o valid.
- tx_ready_i  input  1  encoder took tx_data_o; one gate period.
- busy_o  output  1  packet transaction in progress (state != IDLE).

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, toggle DATA0, byte count 0, CRC 0xFFFF.
  - Reset mid-packet aborts immediately; nothing is committed in the FIFO.
- Every register update below happens only on a clk_i edge with clk_gate_i=1.
- in_ready_o, in_req_o and in_data_ack_o are registered. Each pulse lasts exactly one gate period; all three are 0 otherwise.
- States and transitions:
  - IDLE: on token_in_i, drive in_req_o=1 and in_ready_o=1 for one gate period (FIFO rewinds to the last committed byte). Clear count and CRC. Go to PID.
    - token_in_i in any other state is ignored.
  - PID:
    - tx_data_o=0xC3 (DATA0) or 0x4B (DATA1) per toggle, tx_valid_o=1.
    - On tx_ready_i: go to DATA.
  - DATA:
    - tx_valid_o = in_valid_i & (count < IN_MAXPACKETSIZE); tx_data_o = in_data_i.
    - On tx_ready_i with tx_valid_o=1: pulse in_ready_o (req=0, ack=0), fold the byte into the CRC, count+1.
    - When tx_valid_o is 0 at a gate: go to CRC_LO. This covers FIFO exhausted or max size reached; an empty FIFO gives a zero-length packet.
    - The one-gate bubble is legal: the encoder requests the next byte no sooner than 8 bit times later.
  - CRC_LO: tx_data_o = ~crc[7:0]. On tx_ready_i go to CRC_HI.
  - CRC_HI: tx_data_o = ~crc[15:8]. On tx_ready_i go to WAIT_HS.
  - WAIT_HS:
    - On hs_ack_i: pulse in_ready_o=1 and in_data_ack_o=1 (FIFO commits), flip toggle, go to IDLE.
    - On hs_timeout_i: go to IDLE, no ack, toggle unchanged. The next token resends the same bytes.
    - If hs_ack_i and hs_timeout_i are both high, ack wins.
- CRC16:
  - USB form: reflected polynomial 0xA001, LSB-first byte fold, init 0xFFFF, output inverted, low byte first.
  - Computed combinationally per byte (8 unrolled steps) and registered on acceptance.
- Count width is ceil_log2(IN_MAXPACKETSIZE+1). It is compared against IN_MAXPACKETSIZE, never wraps.
- toggle_clr_i forces DATA0 in any state. If it coincides with the hs_ack_i flip, the clear wins.
- tx_valid_o stays high until tx_ready_i; tx_data_o is held stable while tx_valid_o=1 and no tx_ready_i.

Optional Feature:
- Macro IN_NAK_EMPTY_EN.
- Defined: in PID state, if in_valid_i=0 after the rewind, send a single byte 0x5A (NAK) instead of DATAx and return to IDLE after tx_ready_i. No CRC, no WAIT_HS, no FIFO pulses, toggle unchanged.
- Undefined: an empty FIFO always yields a zero-length DATAx packet: PID, CRC bytes 0x00 0x00, then WAIT_HS.

Test Plan:
- Empty FIFO, toggle DATA0, token_in_i -> tx bytes C3,00,00. Then hs_ack_i -> one in_ready_o+in_data_ack_o pulse, next token sends 0x4B. (With IN_NAK_EMPTY_EN: single byte 5A, toggle stays DATA0.)
- FIFO holds ASCII "123456789", IN_MAXPACKETSIZE=16, token -> tx C3,31..39,C8,B4, exactly 9 data-consume in_ready_o pulses.
- FIFO holds 12 bytes, IN_MAXPACKETSIZE=8 -> 8 payload bytes then CRC. ACK, next token -> remaining 4 bytes with PID 0x4B.
- 4 bytes sent, hs_timeout_i -> no in_data_ack_o, toggle unchanged. Next token -> in_req_o pulse, identical 4 bytes and CRC resent.
- tx_ready_i withheld 20 gate periods in DATA -> tx_data_o/tx_valid_o stable, no in_ready_o pulse.
- rstn_i low during DATA (byte 3) -> all outputs 0 immediately. After release, token resends from byte 0 as DATA0.
